// File: rtl/crc_mem_host_sequencer_pkg.sv
// Shared types and constants for the CRC memory host sequencer.
// The optional statistics counters are enabled by defining CRC_SEQ_STATS_EN.
package crc_seq_pkg;

    localparam int ADDR_W                 = 4;
    localparam int DATA_W                 = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;
    localparam int DEFAULT_CNT_W          = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ISSUE = 3'd1,
        ST_WR_WAIT  = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_RESP     = 3'd5
    } seq_state_e;

endpackage

// File: rtl/crc_mem_host_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
// Instantiated by the sequencer only when CRC_SEQ_STATS_EN is defined.
module crc_seq_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/crc_mem_host_sequencer.sv
// Single-outstanding command sequencer driving the CRC-protected memory top.
// Define CRC_SEQ_STATS_EN to build the rd_count/err_count statistics counters.
module crc_mem_host_sequencer
    import crc_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    // Command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // Response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              rsp_timeout,
    // Memory side
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr_in,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_write_busy,
    input  logic              mem_read_busy,
    input  logic              mem_data_valid,
    input  logic              mem_error_detected,
    input  logic              mem_completed,
    input  logic [DATA_W-1:0] mem_data_out,
    // Statistics
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  err_count,
    // Debug
    output logic [2:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready
    // are both high; a source holds valid and its payload stable until then.

    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wr_q, wr_d;
    logic              seen_busy_q, seen_busy_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_error_q, rsp_error_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [TO_W-1:0]   to_inc;
    logic              to_expire;
    logic              rsp_hs;

    // Timeout fires on the wait cycle whose increment would bring the counter
    // to TIMEOUT_CYCLES-1, so RESP lands TIMEOUT_CYCLES cycles after the issue.
    assign to_inc    = to_cnt_q + TO_W'(1);
    assign to_expire = (to_inc == TO_LAST);
    assign rsp_hs    = (state_q == ST_RESP) && rsp_ready;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        data_d        = data_q;
        wr_d          = wr_q;
        seen_busy_d   = seen_busy_q;
        to_cnt_d      = to_cnt_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    data_d  = cmd_wdata;
                    wr_d    = cmd_write;
                    state_d = cmd_write ? ST_WR_ISSUE : ST_RD_ISSUE;
                end
            end
            ST_WR_ISSUE: begin
                seen_busy_d = 1'b0;
                to_cnt_d    = '0;
                state_d     = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (mem_write_busy) begin
                    seen_busy_d = 1'b1;
                end
                if (seen_busy_q && !mem_write_busy) begin
                    rsp_rdata_d   = '0;
                    rsp_error_d   = 1'b0;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (to_expire) begin
                    rsp_rdata_d   = '0;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    to_cnt_d = to_inc;
                end
            end
            ST_RD_ISSUE: begin
                to_cnt_d = '0;
                state_d  = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (mem_completed) begin
                    rsp_rdata_d   = mem_data_out;
                    rsp_error_d   = mem_error_detected | ~mem_data_valid;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (to_expire) begin
                    rsp_rdata_d   = '0;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    to_cnt_d = to_inc;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            data_q        <= '0;
            wr_q          <= 1'b0;
            seen_busy_q   <= 1'b0;
            to_cnt_q      <= '0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            wr_q          <= wr_d;
            seen_busy_q   <= seen_busy_d;
            to_cnt_q      <= to_cnt_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_write   = wr_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;
    assign mem_write   = (state_q == ST_WR_ISSUE);
    assign mem_read    = (state_q == ST_RD_ISSUE);
    assign mem_addr_in = addr_q;
    assign mem_data_in = data_q;
    assign dbg_state   = state_q;

`ifdef CRC_SEQ_STATS_EN
    crc_seq_sat_counter #(.W(CNT_W)) u_rd_count (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (rsp_hs && !wr_q),
        .count (rd_count)
    );

    crc_seq_sat_counter #(.W(CNT_W)) u_err_count (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (rsp_hs && rsp_error_q),
        .count (err_count)
    );
`else
    assign rd_count  = '0;
    assign err_count = '0;
`endif

    // Read-busy is informational only; completion is signalled by mem_completed.
    logic unused_ok;
    assign unused_ok = mem_read_busy & rsp_hs;

endmodule

// File: doc/crc_mem_host_sequencer.md
# crc_mem_host_sequencer

- Host-side initiator for the CRC-protected faulty memory top. It accepts single read/write commands on a valid/ready channel and drives the memory's one-cycle `write`/`read` pulses. It holds address and data stable for the whole transaction, waits for the memory's busy/completed handshake, and returns one response per command with data, error and timeout status.
- Sits between a testbench or CPU-side command source and the memory top, whose ports it mirrors with a `mem_` prefix.

## Interface
- TIMEOUT_CYCLES, 64: maximum cycles spent in a WAIT state before the transaction is aborted.
- CNT_W, 16: width of the statistics counters.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with `cmd_valid`.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  4  word address.
- cmd_wdata  in  8  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of the command type.
- rsp_rdata  out  8  read data; 0 for writes and timeouts.
- rsp_error  out  1  CRC error, invalid data, or timeout.
- rsp_timeout  out  1  the transaction hit TIMEOUT_CYCLES.
- mem_write, mem_read  out  1  one-cycle request pulses.
- mem_addr_in  out  4  registered address.
- mem_data_in  out  8  registered write data.
- mem_write_busy, mem_read_busy, mem_data_valid, mem_error_detected, mem_completed  in  1  memory status.
- mem_data_out  in  8  decoded read data.
- rd_count, err_count  out  CNT_W  statistics counters.

## Operation
- FSM states: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On handshake, latch the command into `mem_addr_in`/`mem_data_in`/type register.
  - Go to WR_ISSUE or RD_ISSUE.
- WR_ISSUE:
  - `mem_write`=1 for exactly this cycle.
  - Clear `seen_busy` and the timeout counter.
  - Go to WR_WAIT.
- WR_WAIT:
  - Set sticky `seen_busy` when `mem_write_busy`=1.
  - Done when `seen_busy` is set and `mem_write_busy`=0.
  - Go to RESP with `rsp_error`=0.
- RD_ISSUE:
  - `mem_read`=1 for exactly this cycle.
  - Clear the timeout counter.
  - Go to RD_WAIT.
- RD_WAIT:
  - Done on the first cycle with `mem_completed`=1.
  - Capture `rsp_rdata`=`mem_data_out` and `rsp_error`=`mem_error_detected | ~mem_data_valid`.
  - Go to RESP.
- Timeout:
  - In either WAIT state, the counter increments each cycle.
  - When it reaches TIMEOUT_CYCLES-1 without done, go to RESP with `rsp_timeout`=1, `rsp_error`=1, `rsp_rdata`=0.
  - Done has priority over timeout in the same cycle.
- RESP:
  - `rsp_valid`=1 and all `rsp_*` held stable until `rsp_ready`.
  - On handshake, go to IDLE.
- `mem_addr_in`/`mem_data_in` remain unchanged from the command latch until the next accepted command.
- `mem_*` status inputs are ignored outside the WAIT states.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, and all other outputs 0, including `mem_addr_in`, `mem_data_in` and counters.
- A reset asserted mid-transaction aborts it immediately, with no response generated.
- Cycle 0: command handshake.
- Cycle 1: request pulse.
- Cycle 2 onward: WAIT.
- `rsp_valid` rises the cycle after done or timeout is detected.
- Minimum read latency is 3 cycles from handshake to `rsp_valid`. Minimum write latency is 4 cycles, because the busy rise must be observed first.
- `cmd_ready` is low in every state except IDLE, so there is at most one outstanding command.
- Back-to-back spacing: the RESP handshake cycle is followed by an IDLE cycle, then the next handshake.
- Response backpressure: an unbounded `rsp_ready`=0 stalls the block indefinitely, and the timeout counter does not run in RESP.

## Configuration
- Macro: `CRC_SEQ_STATS_EN`.
- Defined:
  - `rd_count` increments on each RESP handshake of a read.
  - `err_count` increments on each RESP handshake with `rsp_error`=1.
  - Both counters saturate at all-ones and clear only on `rst`.
- Undefined: the counters are not built, and both ports are tied to 0.

## Structure
- Package `crc_seq_pkg` holds:
  - the state enum;
  - the address width (4) and data width (8) constants;
  - the default TIMEOUT_CYCLES.
- One sub-module, `crc_seq_sat_counter`: parameterized width, synchronous `clr`/`inc` inputs, asynchronous `rst`. It is instantiated twice under the macro.

## Test plan
- Write 0xA5 to address 3, then read address 3 with fault injection off → write response has error 0; read response has `rsp_rdata`=0xA5, `rsp_error`=0; `rd_count`=1, `err_count`=0.
- Write 0x3C to address 7, then read with `fault_enable`=1, `fault_addr`=0, `burst_error_length`=2 → `rsp_error`=1, `rsp_timeout`=0, `err_count`=1.
- Stub memory with `mem_completed` stuck at 0 and TIMEOUT_CYCLES=16 → `rsp_valid` rises 16 cycles after RD_ISSUE with `rsp_timeout`=1, `rsp_rdata`=0.
- Hold `rsp_ready`=0 for 5 cycles after a read → `rsp_valid` and `rsp_rdata` stay stable, `cmd_ready` stays 0, and `mem_read` pulses exactly once.
- Assert `rst` during RD_WAIT → outputs return to reset values in the same cycle with no response; a subsequent write of 0x11 to address 0 completes normally.
- Build without `CRC_SEQ_STATS_EN` and run the error scenario → `rd_count`=0 and `err_count`=0 throughout.
